// File: rtl/pico_io_hub.sv
// Port-mapped I/O hub for a KCPSM3: decoded output registers, synchronised input
// channels behind a registered read mux, and edge capture on channel 0 with interrupt.
module pico_io_hub #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned N_OUT    = 4,
  parameter int unsigned N_IN     = 4,
  parameter logic [7:0]  BASE_OUT = 8'h00,
  parameter logic [7:0]  BASE_IN  = 8'h80
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               port_id,
  input  logic                     write_strobe,
  input  logic                     read_strobe,
  input  logic [DATA_W-1:0]        out_port,
  output logic [DATA_W-1:0]        in_port,
  output logic                     interrupt,
  input  logic                     interrupt_ack,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  output logic [N_OUT*DATA_W-1:0]  out_data
);

  localparam int unsigned OUT_W = N_OUT * DATA_W;
  localparam int unsigned IN_W  = N_IN * DATA_W;

  localparam logic [7:0] MASK_ADDR = 8'(BASE_OUT + 8'(N_OUT));
  localparam logic [7:0] STAT_ADDR = 8'(BASE_IN + 8'(N_IN));
  localparam logic [7:0] CAPT_ADDR = 8'(BASE_IN + 8'(N_IN + 1));

  logic [OUT_W-1:0]  out_q,     out_d;
  logic [DATA_W-1:0] mask_q,    mask_d;
  logic [IN_W-1:0]   meta_q;
  logic [IN_W-1:0]   sync_q;
  logic [DATA_W-1:0] prev0_q;
  logic [DATA_W-1:0] capture_q, capture_d;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] in_port_q, in_port_d;

  logic [DATA_W-1:0] edges;
  logic              clr;

  // Write decode for output registers and the interrupt mask.
  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    if (write_strobe) begin
      for (int k = 0; k < int'(N_OUT); k++) begin
        if (port_id == 8'(BASE_OUT + 8'(k))) begin
          out_d[k*DATA_W +: DATA_W] = out_port;
        end
      end
      if (port_id == MASK_ADDR) begin
        mask_d = out_port;
      end
    end
  end

  // Edge capture is read-to-clear; a coincident edge survives the clear.
  always_comb begin
    edges     = sync_q[DATA_W-1:0] ^ prev0_q;
    clr       = read_strobe && (port_id == CAPT_ADDR);
    capture_d = (capture_q & ~{DATA_W{clr}}) | edges;
    pending_d = (pending_q & ~interrupt_ack) | (|(edges & mask_q));
  end

  // Read mux; output addresses are write-only and read back as zero.
  always_comb begin
    in_port_d = '0;
    for (int k = 0; k < int'(N_IN); k++) begin
      if (port_id == 8'(BASE_IN + 8'(k))) begin
        in_port_d = sync_q[k*DATA_W +: DATA_W];
      end
    end
    if (port_id == STAT_ADDR) begin
      in_port_d = DATA_W'({pending_q, (|capture_q)});
    end
    if (port_id == CAPT_ADDR) begin
      in_port_d = capture_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      mask_q    <= '0;
      meta_q    <= '0;
      sync_q    <= '0;
      prev0_q   <= '0;
      capture_q <= '0;
      pending_q <= 1'b0;
      in_port_q <= '0;
    end else begin
      out_q     <= out_d;
      mask_q    <= mask_d;
      meta_q    <= in_data;
      sync_q    <= meta_q;
      prev0_q   <= sync_q[DATA_W-1:0];
      capture_q <= capture_d;
      pending_q <= pending_d;
      in_port_q <= in_port_d;
    end
  end

  assign out_data  = out_q;
  assign in_port   = in_port_q;
  assign interrupt = pending_q;

endmodule

// File: tb/tb_pico_io_hub.sv
// Directed bench for pico_io_hub: decode, read mux, capture/interrupt, races, async reset.
module tb_pico_io_hub;

  logic        clk;
  logic        reset;
  logic [7:0]  port_id;
  logic        write_strobe;
  logic        read_strobe;
  logic [7:0]  out_port;
  logic [7:0]  in_port;
  logic        interrupt;
  logic        interrupt_ack;
  logic [31:0] in_data;
  logic [31:0] out_data;

  int n_vec;
  int n_err;

  pico_io_hub #(
    .DATA_W  (8),
    .N_OUT   (4),
    .N_IN    (4),
    .BASE_OUT(8'h00),
    .BASE_IN (8'h80)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack),
    .in_data      (in_data),
    .out_data     (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    port_id      = a;
    out_port     = d;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic test_reset;
    reset         = 1'b1;
    port_id       = 8'h00;
    write_strobe  = 1'b0;
    read_strobe   = 1'b0;
    out_port      = 8'h00;
    interrupt_ack = 1'b0;
    in_data       = 32'h0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_data !== 32'h0) begin
      $display("FAIL reset_out_data: got %h want %h", out_data, 32'h0); n_err++;
    end
    n_vec++;
    if (in_port !== 8'h00) begin
      $display("FAIL reset_in_port: got %h want %h", in_port, 8'h00); n_err++;
    end
    n_vec++;
    if (interrupt !== 1'b0) begin
      $display("FAIL reset_interrupt: got %b want %b", interrupt, 1'b0); n_err++;
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_output_decode;
    wr(8'h00, 8'hA5);
    n_vec++;
    if (out_data !== 32'h0000_00A5) begin
      $display("FAIL decode_reg0: got %h want %h", out_data, 32'h0000_00A5); n_err++;
    end
    wr(8'h03, 8'h3C);
    n_vec++;
    if (out_data !== 32'h3C00_00A5) begin
      $display("FAIL decode_reg3: got %h want %h", out_data, 32'h3C00_00A5); n_err++;
    end
    wr(8'h40, 8'hFF);
    n_vec++;
    if (out_data !== 32'h3C00_00A5) begin
      $display("FAIL decode_unmapped: got %h want %h", out_data, 32'h3C00_00A5); n_err++;
    end
  endtask

  task automatic test_read_mux;
    @(negedge clk);
    in_data[23:16] = 8'h5A;
    repeat (3) @(negedge clk);
    port_id = 8'h82;
    @(negedge clk);
    n_vec++;
    if (in_port !== 8'h5A) begin
      $display("FAIL read_ch2: got %h want %h", in_port, 8'h5A); n_err++;
    end
    port_id = 8'h7F;
    @(negedge clk);
    n_vec++;
    if (in_port !== 8'h00) begin
      $display("FAIL read_unmapped: got %h want %h", in_port, 8'h00); n_err++;
    end
    port_id = 8'h03;
    @(negedge clk);
    n_vec++;
    if (in_port !== 8'h00) begin
      $display("FAIL read_out_addr: got %h want %h", in_port, 8'h00); n_err++;
    end
    port_id = 8'h84;
    @(negedge clk);
    n_vec++;
    if (in_port !== 8'h00) begin
      $display("FAIL read_status_idle: got %h want %h", in_port, 8'h00); n_err++;
    end
  endtask

  task automatic test_capture_irq;
    wr(8'h04, 8'h01);
    n_vec++;
    if (out_data !== 32'h3C00_00A5) begin
      $display("FAIL mask_write_outs: got %h want %h", out_data, 32'h3C00_00A5); n_err++;
    end
    in_data[0] = 1'b1;
    port_id    = 8'h85;
    repeat (2) @(negedge clk);
    n_vec++;
    if (interrupt !== 1'b0) begin
      $display("FAIL irq_early: got %b want %b", interrupt, 1'b0); n_err++;
    end
    @(negedge clk);
    n_vec++;
    if (interrupt !== 1'b1) begin
      $display("FAIL irq_at_3: got %b want %b", interrupt, 1'b1); n_err++;
    end
    @(negedge clk);
    n_vec++;
    if (in_port !== 8'h01) begin
      $display("FAIL capture_bit0: got %h want %h", in_port, 8'h01); n_err++;
    end
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    n_vec++;
    if (interrupt !== 1'b0) begin
      $display("FAIL irq_ack: got %b want %b", interrupt, 1'b0); n_err++;
    end
    n_vec++;
    if (in_port !== 8'h01) begin
      $display("FAIL capture_after_ack: got %h want %h", in_port, 8'h01); n_err++;
    end
    in_data[1] = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++;
    if (in_port !== 8'h03) begin
      $display("FAIL capture_unmasked: got %h want %h", in_port, 8'h03); n_err++;
    end
    n_vec++;
    if (interrupt !== 1'b0) begin
      $display("FAIL irq_unmasked: got %b want %b", interrupt, 1'b0); n_err++;
    end
    port_id = 8'h84;
    @(negedge clk);
    n_vec++;
    if (in_port !== 8'h01) begin
      $display("FAIL status_any: got %h want %h", in_port, 8'h01); n_err++;
    end
  endtask

  task automatic test_read_clear_race;
    port_id     = 8'h85;
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    port_id     = 8'h7F;
    @(negedge clk);
    port_id = 8'h85;
    @(negedge clk);
    n_vec++;
    if (in_port !== 8'h00) begin
      $display("FAIL read_clear: got %h want %h", in_port, 8'h00); n_err++;
    end
    // Re-arm capture=01 via a falling edge on bit 0, then ack the interrupt.
    in_data[0] = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (interrupt !== 1'b1) begin
      $display("FAIL irq_fall_edge: got %b want %b", interrupt, 1'b1); n_err++;
    end
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    n_vec++;
    if (in_port !== 8'h01) begin
      $display("FAIL race_precond: got %h want %h", in_port, 8'h01); n_err++;
    end
    in_data[2] = 1'b1;
    repeat (2) @(negedge clk);
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    n_vec++;
    if (in_port !== 8'h01) begin
      $display("FAIL race_read_value: got %h want %h", in_port, 8'h01); n_err++;
    end
    port_id = 8'h7F;
    @(negedge clk);
    port_id = 8'h85;
    @(negedge clk);
    n_vec++;
    if (in_port !== 8'h04) begin
      $display("FAIL race_edge_kept: got %h want %h", in_port, 8'h04); n_err++;
    end
    n_vec++;
    if (interrupt !== 1'b0) begin
      $display("FAIL race_irq: got %b want %b", interrupt, 1'b0); n_err++;
    end
  endtask

  task automatic test_ack_edge_race;
    in_data[0] = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (interrupt !== 1'b1) begin
      $display("FAIL ack_race_precond: got %b want %b", interrupt, 1'b1); n_err++;
    end
    in_data[0] = 1'b0;
    repeat (2) @(negedge clk);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    n_vec++;
    if (interrupt !== 1'b1) begin
      $display("FAIL ack_race_edge_wins: got %b want %b", interrupt, 1'b1); n_err++;
    end
    @(negedge clk);
    n_vec++;
    if (interrupt !== 1'b1) begin
      $display("FAIL ack_race_hold: got %b want %b", interrupt, 1'b1); n_err++;
    end
    n_vec++;
    if (in_port !== 8'h05) begin
      $display("FAIL ack_race_capture: got %h want %h", in_port, 8'h05); n_err++;
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    #2;
    reset   = 1'b1;
    in_data = 32'h0;
    #1;
    n_vec++;
    if (out_data !== 32'h0) begin
      $display("FAIL async_out_data: got %h want %h", out_data, 32'h0); n_err++;
    end
    n_vec++;
    if (interrupt !== 1'b0) begin
      $display("FAIL async_interrupt: got %b want %b", interrupt, 1'b0); n_err++;
    end
    n_vec++;
    if (in_port !== 8'h00) begin
      $display("FAIL async_in_port: got %h want %h", in_port, 8'h00); n_err++;
    end
    @(negedge clk);
    reset   = 1'b0;
    port_id = 8'h7F;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if (interrupt !== 1'b0) begin
        $display("FAIL post_reset_irq[%0d]: got %b want %b", i, interrupt, 1'b0); n_err++;
      end
    end
    n_vec++;
    if (out_data !== 32'h0) begin
      $display("FAIL post_reset_out: got %h want %h", out_data, 32'h0); n_err++;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_output_decode();
    test_read_mux();
    test_capture_irq();
    test_read_clear_race();
    test_ack_edge_race();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
